fifo_rd_stream_adapter: RTL and testbench

Converts the request/latency-1 read port of a synchronous FIFO into a valid/ready stream master. It sits between a FIFO and any stream consumer and owns every FIFO read decision. It prefetches into a 2-entry skid store, so it sustains one word per clock even when backpressure arrives at any cycle.

---
 rtl/fifo_rd_stream_adapter_pkg.sv | 10 +
 rtl/fifo_rd_stream_adapter_stream_skid_buffer.sv | 69 ++++++
 rtl/fifo_rd_stream_adapter.sv | 74 +++++++
 tb/tb_fifo_rd_stream_adapter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_adapter_pkg.sv
// rtl/fifo_rd_stream_adapter_pkg.sv - shared constants and types for the FIFO read stream adapter
package fifo_rd_stream_adapter_pkg;

  // Prefetch store depth: one word on the stream plus one word of slack for a late ready drop
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;

  typedef logic [SKID_CNT_W-1:0] skid_cnt_t;

endpackage

// File: rtl/fifo_rd_stream_adapter_stream_skid_buffer.sv
// rtl/fifo_rd_stream_adapter_stream_skid_buffer.sv - 2-entry register store with push/pop/flush
module stream_skid_buffer
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ena,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_valid,
  output skid_cnt_t             o_count
);

  skid_cnt_t             count_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] ent0_q;
  logic [DATA_WIDTH-1:0] ent1_q;

  logic      do_pop;
  logic      do_push;
  skid_cnt_t after_pop;
  skid_cnt_t next_count;

  // Pop is applied first, then the pushed word lands in the lowest free slot
  always_comb begin
    do_pop     = i_pop && (count_q != '0);
    after_pop  = count_q - skid_cnt_t'(do_pop);
    do_push    = i_push && (after_pop < skid_cnt_t'(SKID_DEPTH));
    next_count = after_pop + skid_cnt_t'(do_push);
  end

  // Entry 0 is the head; entry 1 shifts forward when the head leaves with both entries full
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
      valid_q <= 1'b0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else if (i_ena) begin
      if (i_flush) begin
        count_q <= '0;
        valid_q <= 1'b0;
      end else begin
        if (do_pop && (count_q == 2'd2)) begin
          ent0_q <= ent1_q;
        end
        if (do_push) begin
          if (after_pop == '0) begin
            ent0_q <= i_push_data;
          end else begin
            ent1_q <= i_push_data;
          end
        end
        count_q <= next_count;
        valid_q <= (next_count != '0);
      end
    end
  end

  assign o_head  = ent0_q;
  assign o_valid = valid_q;
  assign o_count = count_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - latency-1 FIFO read port to valid/ready stream master
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ena,
  input  logic                  i_flush,
  output logic                  o_fifo_rd_req,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [1:0]            o_count,
  output logic [CNT_WIDTH-1:0]  o_xfer_cnt
);

  logic                 inflight_q;
  logic                 discard_q;
  logic [CNT_WIDTH-1:0] xfer_q;
  skid_cnt_t            count;
  logic                 pop;
  logic                 capture;
  logic [2:0]           credit;

  // Words already owned (stored plus in flight) after this cycle's pop decide whether to request more
  always_comb begin
    pop     = i_ena && o_m_valid && i_m_ready;
    capture = i_ena && i_fifo_valid && !discard_q;
    credit  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  end

  assign o_fifo_rd_req = i_rst_n && i_ena && !i_fifo_empty && !i_flush &&
                         (credit < 3'(SKID_DEPTH));

  // Track the outstanding read, drop the return that follows a flush, count handshakes
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      xfer_q     <= '0;
    end else if (i_ena) begin
      inflight_q <= o_fifo_rd_req;
      discard_q  <= i_flush ? inflight_q : 1'b0;
      if (pop) begin
        xfer_q <= xfer_q + CNT_WIDTH'(1);
      end
    end
  end

  stream_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ena       (i_ena),
    .i_flush     (i_flush),
    .i_push      (capture),
    .i_push_data (i_fifo_data),
    .i_pop       (pop),
    .o_head      (o_m_data),
    .o_valid     (o_m_valid),
    .o_count     (count)
  );

  assign o_count    = count;
  assign o_xfer_cnt = xfer_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb/tb_fifo_rd_stream_adapter.sv - directed self-checking bench for fifo_rd_stream_adapter
module tb_fifo_rd_stream_adapter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        flush = 1'b0;
  logic        rd_req;
  logic        f_empty;
  logic [15:0] f_data;
  logic        f_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [1:0]  count;
  logic [3:0]  xfer;

  logic [15:0] mem [0:31];
  int          wptr = 0;
  int          rptr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [1:0]  exp_count;
    logic [3:0]  exp_xfer;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (16),
    .CNT_WIDTH  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ena        (ena),
    .i_flush      (flush),
    .o_fifo_rd_req(rd_req),
    .i_fifo_empty (f_empty),
    .i_fifo_data  (f_data),
    .i_fifo_valid (f_valid),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_count      (count),
    .o_xfer_cnt   (xfer)
  );

  // Synchronous FIFO model: latency-1 read, holds its outputs while disabled
  assign f_empty = (rptr == wptr);
  always @(posedge clk) begin
    if (!rst_n) begin
      rptr    <= 0;
      f_valid <= 1'b0;
      f_data  <= '0;
    end else if (ena) begin
      f_valid <= rd_req;
      if (rd_req) begin
        f_data <= mem[rptr[4:0]];
        rptr   <= rptr + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    if (rst_n && ena && !flush && f_valid && (count == 2'd2) && !(m_valid && m_ready)) begin
      errors++;
      $display("FAIL overflow cycle %0d actual capture at count 2 required none", cyc);
    end
    if (rst_n && ena && (f_valid !== dut.inflight_q)) begin
      errors++;
      $display("FAIL inflight_inv cycle %0d actual %0b required %0b", cyc, dut.inflight_q, f_valid);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   32'(rd_req),  32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_count"}, 32'(count),   32'd0);
    chk({tag, "_xfer"},  32'(xfer),    32'd0);
    chk({tag, "_data"},  32'(m_data),  32'd0);
  endtask

  task automatic do_reset(input int nwords, input logic [15:0] base);
    rst_n   = 1'b0;
    ena     = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    wptr    = 0;
    go();
    go();
    for (int i = 0; i < nwords; i++) mem[i] = base + 16'(i);
    wptr = nwords;
    sample();
    chk_reset_state("reset");
    go();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int          exp_n;
    logic        prev_hold;
    logic [15:0] prev_data;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 4'd0};
    for (int k = 2; k < 8; k++) vecs[k] = '{1'b1, 1'b1, 1'b1, 16'(k - 1), 2'd1, 4'(k - 2)};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0007, 2'd1, 4'd6};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0008, 2'd1, 4'd7};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 4'd8};

    // Back-to-back stream, ready held high
    do_reset(8, 16'h0001);
    for (int k = 0; k < 11; k++) begin
      m_ready = vecs[k].ready;
      sample();
      chk("t1_req",   32'(rd_req),  32'(vecs[k].exp_req));
      chk("t1_valid", 32'(m_valid), 32'(vecs[k].exp_valid));
      chk("t1_count", 32'(count),   32'(vecs[k].exp_count));
      chk("t1_xfer",  32'(xfer),    32'(vecs[k].exp_xfer));
      if (vecs[k].exp_valid) chk("t1_data", 32'(m_data), 32'(vecs[k].exp_data));
      go();
    end

    // Ready toggling 1,0,0,1: order, bound and stability under backpressure
    do_reset(8, 16'h0001);
    exp_n     = 1;
    prev_hold = 1'b0;
    prev_data = '0;
    for (int k = 0; k < 40; k++) begin
      m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      sample();
      chk("t2_count_le2", 32'(count <= 2'd2), 32'd1);
      if (prev_hold) begin
        chk("t2_hold_valid", 32'(m_valid), 32'd1);
        chk("t2_hold_data",  32'(m_data),  32'(prev_data));
      end
      if (m_valid && m_ready) begin
        chk("t2_data", 32'(m_data), 32'(exp_n));
        exp_n++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      go();
    end
    chk("t2_total", 32'(exp_n), 32'd9);
    chk("t2_xfer",  32'(xfer),  32'd8);

    // Ready low from the start: only two words leave the FIFO
    do_reset(5, 16'h0100);
    for (int k = 0; k < 8; k++) begin
      sample();
      go();
    end
    sample();
    chk("t3_count", 32'(count),     32'd2);
    chk("t3_valid", 32'(m_valid),   32'd1);
    chk("t3_data",  32'(m_data),    32'h0100);
    chk("t3_left",  32'(wptr - rptr), 32'd3);
    go();
    m_ready = 1'b1;
    exp_n   = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (m_valid && m_ready) begin
        chk("t3_drain", 32'(m_data), 32'h0100 + 32'(exp_n));
        exp_n++;
      end
      go();
    end
    chk("t3_total", 32'(exp_n), 32'd5);

    // Enable gap right after a request: single capture, no duplicate
    do_reset(3, 16'h0200);
    m_ready = 1'b1;
    sample();
    chk("t4_req0", 32'(rd_req), 32'd1);
    go();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t4_req_off",   32'(rd_req),  32'd0);
      chk("t4_valid_off", 32'(m_valid), 32'd0);
      go();
    end
    ena   = 1'b1;
    exp_n = 0;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (m_valid && m_ready) begin
        chk("t4_data", 32'(m_data), 32'h0200 + 32'(exp_n));
        exp_n++;
      end
      go();
    end
    chk("t4_total", 32'(exp_n), 32'd3);

    // Flush with a word held and a word in flight: next delivered word is 0x00AA
    do_reset(3, 16'h0011);
    mem[2] = 16'h00AA;
    sample();
    go();
    sample();
    go();
    flush = 1'b1;
    sample();
    chk("t5_pre_count", 32'(count),  32'd1);
    chk("t5_pre_data",  32'(m_data), 32'h0011);
    chk("t5_req_flush", 32'(rd_req), 32'd0);
    go();
    flush = 1'b0;
    sample();
    chk("t5_valid_c3", 32'(m_valid), 32'd0);
    chk("t5_count_c3", 32'(count),   32'd0);
    chk("t5_req_c3",   32'(rd_req),  32'd1);
    go();
    sample();
    chk("t5_valid_c4", 32'(m_valid), 32'd0);
    go();
    sample();
    chk("t5_valid_c5", 32'(m_valid), 32'd1);
    chk("t5_data_c5",  32'(m_data),  32'h00AA);
    chk("t5_count_c5", 32'(count),   32'd1);
    go();
    m_ready = 1'b1;
    sample();
    chk("t5_data_c6", 32'(m_data), 32'h00AA);
    go();
    sample();
    chk("t5_valid_c7", 32'(m_valid), 32'd0);
    chk("t5_xfer_c7",  32'(xfer),    32'd1);
    go();

    // Transfer counter wraps at 2^4
    do_reset(17, 16'h0300);
    m_ready = 1'b1;
    exp_n   = 0;
    for (int k = 0; k < 22; k++) begin
      sample();
      if (m_valid && m_ready) exp_n++;
      go();
    end
    chk("t6_pops", 32'(exp_n), 32'd17);
    chk("t6_wrap", 32'(xfer),  32'd1);

    // Reset asserted mid-stream
    do_reset(10, 16'h0400);
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      go();
    end
    sample();
    chk("t7_busy_valid", 32'(m_valid), 32'd1);
    go();
    rst_n = 1'b0;
    go();
    sample();
    chk_reset_state("t7_mid");
    go();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
